// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory-mapped slave.
package apb_mem_pkg;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   localparam int unsigned DefDataWidth  = 32;
   localparam int unsigned DefAddrWidth  = 32;
   localparam int unsigned DefMemDepth   = 256;
   localparam int unsigned DefWaitStates = 0;
   localparam int unsigned WaitCntWidth  = 4;

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/apb_mem_regfile.sv
// Word-wide register file: async clear, one write port, one combinational read port.
module apb_mem_regfile #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned IDX_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB-style slave: SETUP/ACCESS FSM with programmable wait states over a word register file.
module apb_mem_slave
   import apb_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DefDataWidth,
   parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
   parameter int unsigned MEM_DEPTH   = DefMemDepth,
   parameter int unsigned WAIT_STATES = DefWaitStates
) (
   input  logic                  pclk,
   input  logic                  rst_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   inout  wire  [DATA_WIDTH-1:0] pdata,
   output logic                  pready
);

   localparam int unsigned IdxW = idx_width(MEM_DEPTH);
   localparam logic [WaitCntWidth-1:0] WaitMax = WaitCntWidth'(WAIT_STATES);

   state_e                  state_q;
   logic [IdxW-1:0]         idx_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [WaitCntWidth-1:0] wait_q;

   logic [IdxW-1:0]       bus_idx;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  in_access;
   logic                  pready_w;
   logic                  drive_en;
   logic                  unused_addr_bits;

   // High address bits and byte offset alias onto the word index.
   assign bus_idx          = paddr[IdxW+1:2];
   assign unused_addr_bits = ^{paddr[ADDR_WIDTH-1:IdxW+2], paddr[1:0]};

   assign in_access = (state_q == StAccess);
   assign pready_w  = in_access & psel & penable & (wait_q == WaitMax);
   assign drive_en  = in_access & psel & penable & ~write_q;
   assign pready    = pready_w;
   assign pdata     = drive_en ? rdata_q : {DATA_WIDTH{1'bz}};

   apb_mem_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH),
      .IDX_W      (IdxW)
   ) u_regfile (
      .clk   (pclk),
      .rst_n (rst_n),
      .we    (pready_w & write_q),
      .waddr (idx_q),
      .wdata (pdata),
      .raddr (bus_idx),
      .rdata (mem_rdata)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         wait_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (psel && !penable) state_q <= StSetup;
            end
            StSetup: begin
               idx_q   <= bus_idx;
               write_q <= pwrite;
               wait_q  <= '0;
               if (!pwrite) rdata_q <= mem_rdata;
               state_q <= StAccess;
            end
            StAccess: begin
               if (pready_w) begin
                  state_q <= (psel && !penable) ? StSetup : StIdle;
               end else if (!psel) begin
                  state_q <= StIdle;
               end else if (wait_q != WaitMax) begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: driver queues expected read data, monitor checks the bus.
module tb_apb_mem_slave;

   localparam int unsigned WS    = 3;
   localparam int unsigned DEPTH = 256;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic        drv_en = 1'b0;
   logic [31:0] drv_data = '0;
   logic        pready;
   wire  [31:0] pdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_q [$];

   assign pdata = drv_en ? drv_data : 'z;

   always #5 pclk = ~pclk;

   apb_mem_slave #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .MEM_DEPTH   (DEPTH),
      .WAIT_STATES (WS)
   ) dut (
      .pclk    (pclk),
      .rst_n   (rst_n),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pdata   (pdata),
      .pready  (pready)
   );

   function automatic int unsigned word_idx(input logic [31:0] addr);
      return (addr / 4) % DEPTH;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, want);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
   endtask

   // Monitor: every completing read is checked against the oldest queued expectation.
   always @(negedge pclk) begin
      if (rst_n && pready && psel && penable && !pwrite) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read", pdata, 32'hxxxx_xxxx);
         end else begin
            check("read_data", pdata, exp_q.pop_front());
         end
      end
   end

   // Called 1 time unit after a rising edge; returns at the same phase after completion.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      int n;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
      drv_en = wr; drv_data = data;
      if (!wr) exp_q.push_back(model_mem[word_idx(addr)]);
      @(posedge pclk); #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!pready && n < 50);
      check("latency", 32'(n), 32'(2 + WS));
      @(posedge pclk); #1;
      if (wr) model_mem[word_idx(addr)] = data;
      psel = 1'b0; penable = 1'b0; drv_en = 1'b0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(posedge pclk); #1;
      end
   endtask

   initial begin
      clear_model();
      idle(2);
      rst_n = 1'b1;
      @(negedge pclk);
      check("reset_pready", 32'(pready), 32'd0);
      @(posedge pclk); #1;

      // Reset in the middle of a write wipes memory and aborts the transfer.
      xfer(1'b1, 32'h10, 32'h1234_5678);
      psel = 1'b1; pwrite = 1'b1; paddr = 32'h10; drv_en = 1'b1; drv_data = 32'h9999_0000;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      rst_n = 1'b0;
      #1;
      check("pready_in_reset", 32'(pready), 32'd0);
      psel = 1'b0; penable = 1'b0; drv_en = 1'b0;
      clear_model();
      @(posedge pclk); #1;
      rst_n = 1'b1;
      idle(1);
      xfer(1'b0, 32'h10, '0);

      // Aborted write: psel drops after one wait cycle.
      psel = 1'b1; pwrite = 1'b1; paddr = 32'h08; drv_en = 1'b1; drv_data = 32'hCAFE_F00D;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; drv_en = 1'b0;
      idle(2);
      xfer(1'b0, 32'h08, '0);

      // Basic write/read and back-to-back aliasing.
      xfer(1'b1, 32'h04, 32'hDEAD_BEEF);
      xfer(1'b0, 32'h04, '0);
      xfer(1'b1, 32'h20, 32'hA5A5_A5A5);
      idle(1);
      xfer(1'b0, 32'h20, '0);
      xfer(1'b1, 32'h00, 32'h1111_1111);
      xfer(1'b1, 32'h400, 32'h2222_2222);
      xfer(1'b0, 32'h00, '0);
      xfer(1'b1, 32'h03, 32'h3333_3333);
      xfer(1'b0, 32'h00, '0);

      // Protocol noise: penable without psel is ignored.
      penable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         check("noise_pready", 32'(pready), 32'd0);
      end
      @(posedge pclk); #1;
      penable = 1'b0;
      xfer(1'b0, 32'h00, '0);
      xfer(1'b0, 32'h04, '0);

      // Randomized traffic over an aliasing address range.
      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         a = $urandom & 32'h0000_0FFF;
         d = $urandom;
         xfer(1'($urandom_range(0, 1)), a, d);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end

      idle(3);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
